tick_timer: RTL and testbench
=============================

# tick_timer

Parametrised multi-channel timer for the game logic. A free-running prescaler divides the system clock into a base tick (1 ms at default settings). Each of CHANNELS independent channels counts a programmable number of base ticks and signals expiry in one-shot or periodic mode. It generalises the fixed single-output millisecond divider: game timers (ghost mode changes, fruit timeout, animation rate) start, stop and reload at runtime instead of each needing a dedicated divider.

## Interface
Parameters:
- PRESCALE, default 100000: clk cycles per base tick, minimum 2.
- CHANNELS, default 4: number of independent timer channels, minimum 1.
- CNT_W, default 16: width of the per-channel period and counter.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  CHANNELS  per-channel one-cycle start/restart request.
- stop  in  CHANNELS  per-channel one-cycle stop request.
- oneshot  in  CHANNELS  per-channel mode, sampled with start: 1 = one-shot, 0 = periodic.
- period  in  CHANNELS*CNT_W  per-channel period in base ticks; channel i uses bits [i*CNT_W +: CNT_W], sampled with start.
- base_tick  out  1  one-cycle pulse once every PRESCALE clk cycles.
- expire  out  CHANNELS  one-cycle expiry pulse per channel.
- active  out  CHANNELS  1 while the channel is in RUN.
- wave  out  CHANNELS  per-channel square wave; present only with TICK_TIMER_WAVE_EN.

## Operation
- Reset values: prescaler = 0, every channel IDLE with counter = 0 and latched period = 0. All outputs are 0: base_tick, expire, active, wave.
- Prescaler: counts 0..PRESCALE-1 and wraps. It runs freely from reset and is never affected by the channels. Width is $clog2(PRESCALE).
- base_tick is registered. It is high for the one cycle after the prescaler reaches PRESCALE-1.
- Channel FSM has two states, IDLE and RUN. active = (state == RUN).
- start with a nonzero period, from either state:
  - load the counter from period;
  - latch period and oneshot;
  - go to RUN.
- start with period == 0 is ignored: no change to state, counter, latched values or outputs.
- stop goes to IDLE from either state. No expire pulse. The counter holds its value, which is don't-care.
- start and stop in the same cycle: stop wins.
- In RUN, on a base_tick cycle with no start or stop:
  - If the counter is greater than 1, decrement it.
  - If the counter equals 1, pulse expire next cycle. Then, if periodic, reload the latched period and stay in RUN; if one-shot, go to IDLE.
- start coincident with base_tick: the reload wins and that tick is not counted.
- stop coincident with the terminal tick: no expire, go to IDLE.
- Arithmetic is unsigned CNT_W. The counter never underflows because the terminal value is 1.
- Period and mode inputs are ignored outside start cycles. Changing them mid-run has no effect until the next start.

## Timing
- base_tick period is exactly PRESCALE clk cycles. The first pulse comes PRESCALE cycles after rst deasserts.
- active rises one cycle after start is sampled.
- Periodic channel: expire pulses exactly P*PRESCALE cycles apart, where P is the latched period.
- First expiry after start: between (P-1)*PRESCALE+1 and P*PRESCALE cycles after start is sampled, depending on prescaler phase.
- Expiry latency: expire is asserted in the same cycle as the base_tick pulse that decrements the counter from 1. A one-shot channel's active falls in that same cycle.
- Reset mid-operation: all outputs go to 0 asynchronously and every channel returns to IDLE. No expire pulse is emitted.

## Configuration
- TICK_TIMER_WAVE_EN defined:
  - wave[i] toggles on every expire[i] pulse, in the same cycle the pulse is asserted.
  - wave[i] resets to 0 and holds its value while the channel is IDLE.
  - A periodic channel therefore produces a square wave of period 2*P*PRESCALE cycles.
- TICK_TIMER_WAVE_EN undefined: the wave port and its registers are absent.

## Test plan
All scenarios use PRESCALE=4, CHANNELS=2, CNT_W=8.
- Reset release, no start -> base_tick pulses at cycles 4, 8, 12 after release; expire and active stay 0.
- Channel 0: start with period=3, oneshot=0 -> expire[0] pulses every 12 cycles, at least 4 times; active[0] stays 1.
- Channel 1: start with period=2, oneshot=1 -> exactly one expire[1] pulse, between 5 and 8 cycles after start; active[1] falls in the same cycle.
- stop[0] in the cycle before the terminal tick -> no expire[0]; active[0] 0 next cycle. start and stop together -> channel IDLE.
- start with period=0 while RUN with period=3 -> ignored; periodic expiry continues unchanged. Restart with period=5 mid-count -> next expiry 17 to 20 cycles later.
- With TICK_TIMER_WAVE_EN, channel periodic with period=1 -> wave toggles every 4 cycles; rst asserted mid-run -> wave, active and expire go to 0 immediately.

Source files
------------

// File: rtl/tick_timer.sv
// tick_timer: free-running prescaler producing a base tick, plus CHANNELS
//   independent one-shot/periodic countdown channels clocked by that tick.
// Latency: expire is asserted in the same cycle as the base_tick pulse of the terminal tick.
// Backpressure: none; start/stop are one-cycle requests, and stop wins over start.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   start/stop      per-channel one-cycle start (restart) / stop requests
//   oneshot/period  per-channel mode and period (base ticks), sampled with start
//   base_tick       one-cycle pulse every PRESCALE clk cycles
//   expire/active   per-channel expiry pulse / channel-running flag
//   wave            per-channel square wave, only when TICK_TIMER_WAVE_EN is defined
module tick_timer #(
  parameter int PRESCALE = 100000,
  parameter int CHANNELS = 4,
  parameter int CNT_W    = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CHANNELS-1:0]       start,
  input  logic [CHANNELS-1:0]       stop,
  input  logic [CHANNELS-1:0]       oneshot,
  input  logic [CHANNELS*CNT_W-1:0] period,
  output logic                      base_tick,
  output logic [CHANNELS-1:0]       expire,
  output logic [CHANNELS-1:0]       active
`ifdef TICK_TIMER_WAVE_EN
  ,
  output logic [CHANNELS-1:0]       wave
`endif
);

  localparam int PS_W = $clog2(PRESCALE);
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

  typedef enum logic {IDLE, RUN} state_t;

  logic [PS_W-1:0] ps_cnt;
  logic            tick;

  // tick is the cycle in which the prescaler sits at its last value; the
  // channels act on it at the same edge that registers base_tick, so expire
  // and base_tick appear together.
  assign tick = (ps_cnt == PS_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ps_cnt    <= '0;
      base_tick <= 1'b0;
    end else begin
      base_tick <= tick;
      ps_cnt    <= tick ? '0 : ps_cnt + PS_W'(1);
    end
  end

  genvar i;
  generate
    for (i = 0; i < CHANNELS; i++) begin : g_ch
      state_t           state;
      logic [CNT_W-1:0] cnt;
      logic [CNT_W-1:0] per_q;
      logic             os_q;
      logic             exp_q;
      logic [CNT_W-1:0] per_in;
`ifdef TICK_TIMER_WAVE_EN
      logic             wave_q;
      assign wave[i] = wave_q;
`endif

      assign per_in    = period[i*CNT_W +: CNT_W];
      assign expire[i] = exp_q;
      assign active[i] = (state == RUN);

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          state <= IDLE;
          cnt   <= '0;
          per_q <= '0;
          os_q  <= 1'b0;
          exp_q <= 1'b0;
`ifdef TICK_TIMER_WAVE_EN
          wave_q <= 1'b0;
`endif
        end else begin
          exp_q <= 1'b0;
          if (stop[i]) begin
            // Counter is left as-is; it is reloaded by the next start.
            state <= IDLE;
          end else if (start[i] && per_in != '0) begin
            // A start on a tick cycle reloads and that tick is not counted.
            cnt   <= per_in;
            per_q <= per_in;
            os_q  <= oneshot[i];
            state <= RUN;
          end else if (state == RUN && tick) begin
            if (cnt > CNT_W'(1)) begin
              cnt <= cnt - CNT_W'(1);
            end else begin
              // Terminal value is 1, so the counter never wraps below zero.
              exp_q <= 1'b1;
`ifdef TICK_TIMER_WAVE_EN
              wave_q <= ~wave_q;
`endif
              if (os_q) state <= IDLE;
              else      cnt   <= per_q;
            end
          end
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_tick_timer.sv
// Bench for tick_timer with PRESCALE=4, CHANNELS=2, CNT_W=8.
// Reference model tracks expiry deadlines as absolute edge numbers since reset.
module tb_tick_timer;

  localparam int PRESCALE = 4;
  localparam int CHANNELS = 2;
  localparam int CNT_W    = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [1:0]  start = '0;
  logic [1:0]  stop = '0;
  logic [1:0]  oneshot = '0;
  logic [15:0] period = '0;
  logic        base_tick;
  logic [1:0]  expire;
  logic [1:0]  active;
  logic [1:0]  wave;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  tick_timer #(.PRESCALE(PRESCALE), .CHANNELS(CHANNELS), .CNT_W(CNT_W)) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .stop(stop),
    .oneshot(oneshot),
    .period(period),
    .base_tick(base_tick),
    .expire(expire),
    .active(active)
`ifdef TICK_TIMER_WAVE_EN
    ,
    .wave(wave)
`endif
  );

`ifndef TICK_TIMER_WAVE_EN
  assign wave = 2'b00;
`endif

  // Reference model: n counts rising edges since reset release; ticks land
  // on edges that are multiples of PRESCALE. A start at edge n with period p
  // expires on the p-th tick edge strictly after n.
  int       n = 0;
  bit       m_bt = 0;
  bit [1:0] m_exp = '0;
  bit [1:0] m_act = '0;
  bit [1:0] m_wave = '0;
  int       m_dl [2];
  int       m_per [2];
  bit       m_os [2];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      n = 0; m_bt = 0; m_exp = '0; m_act = '0; m_wave = '0;
    end else begin
      n++;
      m_bt  = (n % PRESCALE == 0);
      m_exp = '0;
      for (int c = 0; c < CHANNELS; c++) begin
        int p;
        p = int'(period[c*CNT_W +: CNT_W]);
        if (stop[c]) begin
          m_act[c] = 0;
        end else if (start[c] && p != 0) begin
          m_act[c] = 1;
          m_per[c] = p;
          m_os[c]  = oneshot[c];
          m_dl[c]  = (n / PRESCALE + p) * PRESCALE;
        end else if (m_act[c] && n == m_dl[c]) begin
          m_exp[c]  = 1;
          m_wave[c] = ~m_wave[c];
          if (m_os[c]) m_act[c] = 0;
          else         m_dl[c] = m_dl[c] + m_per[c] * PRESCALE;
        end
      end
    end
  end

  function automatic logic [6:0] obs_v();
    return {base_tick, expire, active, wave};
  endfunction

  function automatic logic [6:0] exp_v();
`ifdef TICK_TIMER_WAVE_EN
    return {m_bt, m_exp, m_act, m_wave};
`else
    return {m_bt, m_exp, m_act, 2'b00};
`endif
  endfunction

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(); step();
    checks++;
    if (obs_v() !== 7'b0) begin
      errors++; $display("FAIL reset_outputs got=%b want=%b", obs_v(), 7'b0);
    end
    rst = 1'b0;
    for (int c = 1; c <= 13; c++) begin
      step();
      checks++;
      if (base_tick !== 1'(c % 4 == 0) || expire !== 2'b00 || active !== 2'b00) begin
        errors++;
        $display("FAIL idle_tick_phase cycle=%0d got bt=%b exp=%b act=%b want bt=%b exp=00 act=00",
                 c, base_tick, expire, active, (c % 4 == 0));
      end
      checks++;
      if (obs_v() !== exp_v()) begin
        errors++; $display("FAIL idle_model cycle=%0d got=%b want=%b", c, obs_v(), exp_v());
      end
    end
  endtask

  task automatic test_periodic();
    int last, nexp;
    last = -1; nexp = 0;
    period[7:0] = 8'd3; oneshot[0] = 1'b0; start[0] = 1'b1;
    step();
    start[0] = 1'b0;
    checks++;
    if (active[0] !== 1'b1) begin
      errors++; $display("FAIL periodic_active_rise got=%b want=1", active[0]);
    end
    for (int c = 0; c < 60; c++) begin
      step();
      checks++;
      if (obs_v() !== exp_v() || active[0] !== 1'b1) begin
        errors++; $display("FAIL periodic_model n=%0d got=%b want=%b", n, obs_v(), exp_v());
      end
      if (expire[0] === 1'b1) begin
        if (last >= 0) begin
          checks++;
          if (n - last != 12) begin
            errors++; $display("FAIL periodic_interval got=%0d want=12", n - last);
          end
        end
        last = n; nexp++;
      end
    end
    checks++;
    if (nexp < 4) begin
      errors++; $display("FAIL periodic_count got=%0d want>=4", nexp);
    end
  endtask

  task automatic test_oneshot();
    int s, nexp;
    nexp = 0;
    period[15:8] = 8'd2; oneshot[1] = 1'b1; start[1] = 1'b1;
    step();
    start[1] = 1'b0; s = n;
    for (int c = 0; c < 14; c++) begin
      step();
      checks++;
      if (obs_v() !== exp_v()) begin
        errors++; $display("FAIL oneshot_model n=%0d got=%b want=%b", n, obs_v(), exp_v());
      end
      if (expire[1] === 1'b1) begin
        nexp++;
        checks++;
        if (n - s < 5 || n - s > 8 || active[1] !== 1'b0) begin
          errors++; $display("FAIL oneshot_delay got=%0d act=%b want 5..8 act=0", n - s, active[1]);
        end
      end
    end
    checks++;
    if (nexp != 1 || active[1] !== 1'b0) begin
      errors++; $display("FAIL oneshot_count got=%0d act=%b want=1 act=0", nexp, active[1]);
    end
  endtask

  task automatic test_stop();
    bit found, seen;
    found = 0; seen = 0;
    // Channel 0 is still periodic with period 3; align so stop lands one edge before its terminal tick.
    for (int c = 0; c < 20 && !found; c++) begin
      if (m_dl[0] - n == 2) found = 1;
      else step();
    end
    checks++;
    if (!found) begin
      errors++; $display("FAIL stop_align got=timeout want=aligned");
    end
    stop[0] = 1'b1;
    step();
    stop[0] = 1'b0;
    checks++;
    if (active[0] !== 1'b0) begin
      errors++; $display("FAIL stop_active got=%b want=0", active[0]);
    end
    for (int c = 0; c < 20; c++) begin
      step();
      if (expire[0] === 1'b1) seen = 1;
    end
    checks++;
    if (seen) begin
      errors++; $display("FAIL stop_no_expire got=1 want=0");
    end
    period[7:0] = 8'd3; start[0] = 1'b1; stop[0] = 1'b1;
    step();
    start[0] = 1'b0; stop[0] = 1'b0;
    checks++;
    if (active[0] !== 1'b0 || obs_v() !== exp_v()) begin
      errors++; $display("FAIL start_stop_same got act=%b want act=0", active[0]);
    end
  endtask

  task automatic test_zero_restart();
    int e1, e2, s;
    e1 = -1; e2 = -1;
    period[7:0] = 8'd3; oneshot[0] = 1'b0; start[0] = 1'b1;
    step();
    start[0] = 1'b0;
    for (int c = 0; c < 20 && e1 < 0; c++) begin
      step();
      if (expire[0] === 1'b1) e1 = n;
    end
    repeat (5) step();
    period[7:0] = 8'd0; start[0] = 1'b1;
    step();
    start[0] = 1'b0; period[7:0] = 8'd7;
    for (int c = 0; c < 20 && e2 < 0; c++) begin
      step();
      if (expire[0] === 1'b1) e2 = n;
    end
    checks++;
    if (e1 < 0 || e2 - e1 != 12 || active[0] !== 1'b1) begin
      errors++; $display("FAIL zero_period_ignored got=%0d act=%b want=12 act=1", e2 - e1, active[0]);
    end
    repeat (3) step();
    period[7:0] = 8'd5; start[0] = 1'b1;
    step();
    start[0] = 1'b0; s = n; e2 = -1;
    for (int c = 0; c < 30 && e2 < 0; c++) begin
      step();
      if (expire[0] === 1'b1) e2 = n;
    end
    checks++;
    if (e2 < 0 || e2 - s < 17 || e2 - s > 20) begin
      errors++; $display("FAIL restart_delay got=%0d want 17..20", e2 - s);
    end
  endtask

  task automatic test_random();
    int bad;
    bad = 0;
    for (int c = 0; c < 600; c++) begin
      for (int ch = 0; ch < CHANNELS; ch++) begin
        start[ch]   = ($urandom_range(0, 7) == 0);
        stop[ch]    = ($urandom_range(0, 24) == 0);
        oneshot[ch] = 1'($urandom_range(0, 1));
        period[ch*CNT_W +: CNT_W] = 8'($urandom_range(0, 4));
      end
      step();
      checks++;
      if (obs_v() !== exp_v()) begin
        errors++; bad++;
        if (bad < 10) $display("FAIL random_model n=%0d got=%b want=%b", n, obs_v(), exp_v());
      end
    end
    start = '0; stop = '0;
  endtask

`ifdef TICK_TIMER_WAVE_EN
  task automatic test_wave();
    logic [1:0] w0;
    logic       prev;
    int         last, tog;
    last = -1; tog = 0;
    stop = 2'b11;
    step();
    stop = 2'b00; w0 = wave;
    repeat (6) step();
    checks++;
    if (wave !== w0) begin
      errors++; $display("FAIL wave_hold_idle got=%b want=%b", wave, w0);
    end
    period[7:0] = 8'd1; oneshot[0] = 1'b0; start[0] = 1'b1;
    step();
    start[0] = 1'b0; prev = wave[0];
    for (int c = 0; c < 24; c++) begin
      step();
      if (wave[0] !== prev) begin
        if (last >= 0) begin
          checks++;
          if (n - last != 4) begin
            errors++; $display("FAIL wave_interval got=%0d want=4", n - last);
          end
        end
        last = n; tog++; prev = wave[0];
      end
    end
    checks++;
    if (tog < 5) begin
      errors++; $display("FAIL wave_toggles got=%0d want>=5", tog);
    end
  endtask
`endif

  task automatic test_async_reset();
    period[7:0] = 8'd1; oneshot[0] = 1'b0; start[0] = 1'b1;
    step();
    start[0] = 1'b0;
    repeat (6) step();
    #2 rst = 1'b1;
    #1;
    checks++;
    if (obs_v() !== 7'b0) begin
      errors++; $display("FAIL async_reset got=%b want=%b", obs_v(), 7'b0);
    end
    step();
    rst = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      step();
      checks++;
      if (obs_v() !== exp_v() || active !== 2'b00) begin
        errors++; $display("FAIL post_reset cycle=%0d got=%b want=%b", c, obs_v(), exp_v());
      end
    end
  endtask

  initial begin
    test_reset();
    test_periodic();
    test_oneshot();
    test_stop();
    test_zero_restart();
    test_random();
`ifdef TICK_TIMER_WAVE_EN
    test_wave();
`endif
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
